// File: rtl/oddr_lane_serializer.sv
`default_nettype none
// ============================================================================
// Module   : oddr_lane_serializer
// Purpose  : Multi-lane SDR/DDR pad serializer with word-pair FIFO, OE and
//            underrun flag. Optional underrun counter: ODDR_UNDERRUN_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module oddr_lane_serializer #(
  parameter int   WIDTH    = 8,
  parameter int   DEPTH    = 4,
  parameter logic IDLE_VAL = 1'b1
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic             ddr_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d1,
  input  logic [WIDTH-1:0] in_d2,
  input  logic             in_last,
  output logic [WIDTH-1:0] Q,
  output logic             OE,
  output logic             busy,
  output logic             underrun,
  input  logic             clr_underrun,
  output logic [7:0]       underrun_cnt
);

  localparam int               c_AW   = $clog2(DEPTH);
  localparam int               c_CW   = c_AW + 1;
  localparam logic [c_CW-1:0]  c_FULL = c_CW'(DEPTH);
  localparam logic [WIDTH-1:0] c_IDLE = {WIDTH{IDLE_VAL}};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_mem_d1   [DEPTH];
  logic [WIDTH-1:0] r_mem_d2   [DEPTH];
  logic             r_mem_last [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic [c_CW-1:0]  w_count_nxt;
  logic             r_in_ready;

  logic [WIDTH-1:0] r_pos;
  logic [WIDTH-1:0] r_neg;
  logic             r_oe;
  logic             r_last_popped;
  logic             r_underrun;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_load_word;
  logic w_load_idle;
  logic w_oe_nxt;
  logic w_urun;

  assign w_empty = (r_count == '0);
  assign w_push  = CE & in_valid & r_in_ready;

  // FSM next-state / control
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load_word = 1'b0;
    w_load_idle = 1'b0;
    w_oe_nxt    = r_oe;
    w_urun      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_load_word = 1'b1;
          w_oe_nxt    = 1'b1;
          w_state_nxt = ST_STREAM;
        end else begin
          w_load_idle = 1'b1;
          w_oe_nxt    = 1'b0;
        end
      end
      ST_STREAM: begin
        if (r_last_popped) begin
          w_load_idle = 1'b1;
          w_oe_nxt    = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_load_word = 1'b1;
        end else begin
          w_load_idle = 1'b1;
          w_urun      = 1'b1;
        end
      end
      default: begin
        w_load_idle = 1'b1;
        w_oe_nxt    = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + 1'b1;
    else if (!w_push && w_pop)
      w_count_nxt = r_count - 1'b1;
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge C) begin
    if (!R && w_push) begin
      r_mem_d1[r_wr_ptr]   <= in_d1;
      r_mem_d2[r_wr_ptr]   <= in_d2;
      r_mem_last[r_wr_ptr] <= in_last;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else if (CE) begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != c_FULL);
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      r_state       <= ST_IDLE;
      r_pos         <= c_IDLE;
      r_neg         <= c_IDLE;
      r_oe          <= 1'b0;
      r_last_popped <= 1'b0;
    end else if (CE) begin
      r_state <= w_state_nxt;
      r_oe    <= w_oe_nxt;
      if (w_load_word) begin
        // ddr_mode is captured per word, here at pop time
        r_pos         <= r_mem_d1[r_rd_ptr];
        r_neg         <= ddr_mode ? r_mem_d2[r_rd_ptr] : r_mem_d1[r_rd_ptr];
        r_last_popped <= r_mem_last[r_rd_ptr];
      end else if (w_load_idle) begin
        r_pos         <= c_IDLE;
        r_neg         <= c_IDLE;
        r_last_popped <= 1'b0;
      end
    end
  end

  always_ff @(posedge C) begin
    if (R)
      r_underrun <= 1'b0;
    else if (CE) begin
      if (w_urun)
        r_underrun <= 1'b1;
      else if (clr_underrun)
        r_underrun <= 1'b0;
    end
  end

`ifdef ODDR_UNDERRUN_CNT_EN
  logic [7:0] r_urun_cnt;

  always_ff @(posedge C) begin
    if (R)
      r_urun_cnt <= 8'd0;
    else if (CE) begin
      if (clr_underrun)
        r_urun_cnt <= 8'd0;
      else if (w_urun && (r_urun_cnt != 8'hFF))
        r_urun_cnt <= r_urun_cnt + 8'd1;
    end
  end

  assign underrun_cnt = r_urun_cnt;
`else
  assign underrun_cnt = 8'd0;
`endif

  assign Q        = C ? r_pos : r_neg;
  assign OE       = r_oe;
  assign in_ready = r_in_ready;
  assign underrun = r_underrun;
  assign busy     = (r_state != ST_IDLE) | !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_oddr_lane_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_oddr_lane_serializer
// Purpose  : Directed self-checking bench for oddr_lane_serializer (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_oddr_lane_serializer;

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic       CE = 1'b1;
  logic       ddr_mode = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_d1 = 8'h00;
  logic [7:0] in_d2 = 8'h00;
  logic       in_last = 1'b0;
  logic [7:0] Q;
  logic       OE;
  logic       busy;
  logic       underrun;
  logic       clr_underrun = 1'b0;
  logic [7:0] underrun_cnt;

  int n_checks = 0;
  int n_errors = 0;

  oddr_lane_serializer #(.WIDTH(8), .DEPTH(4), .IDLE_VAL(1'b1)) dut (
    .C(C), .R(R), .CE(CE), .ddr_mode(ddr_mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_d1(in_d1), .in_d2(in_d2), .in_last(in_last),
    .Q(Q), .OE(OE), .busy(busy), .underrun(underrun),
    .clr_underrun(clr_underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 C = ~C;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Sample in the high half (Q = pos_flop) or the low half (Q = neg_flop)
  task automatic tick;
    @(posedge C);
    #1;
  endtask

  task automatic half_lo;
    @(negedge C);
    #1;
  endtask

  localparam logic [7:0] c_EXP_CNT3 =
`ifdef ODDR_UNDERRUN_CNT_EN
    8'd3;
`else
    8'd0;
`endif

  int exp_rdy [1:9] = '{1, 1, 1, 1, 1, 1, 0, 1, 0};

  initial begin
    int         pushed;
    logic       rdy_before;
    logic [7:0] exp_q;

    tick; tick;
    R = 1'b0;
    check_val("rst_q", Q, 8'hFF);
    check_val("rst_oe", OE, 1'b0);
    check_val("rst_ready", in_ready, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_urun", underrun, 1'b0);
    check_val("rst_ucnt", underrun_cnt, 8'd0);
    half_lo;
    check_val("rst_q_lo", Q, 8'hFF);

    // 1: DDR burst of two words
    ddr_mode = 1'b1;
    in_valid = 1'b1; in_d1 = 8'hA5; in_d2 = 8'h5A; in_last = 1'b0;
    tick;
    check_val("t1_q_pre", Q, 8'hFF);
    in_d1 = 8'h3C; in_d2 = 8'hC3; in_last = 1'b1;
    tick;
    in_valid = 1'b0; in_last = 1'b0;
    check_val("t1_q0_hi", Q, 8'hA5);
    check_val("t1_oe0", OE, 1'b1);
    half_lo;
    check_val("t1_q0_lo", Q, 8'h5A);
    tick;
    check_val("t1_q1_hi", Q, 8'h3C);
    check_val("t1_oe1", OE, 1'b1);
    half_lo;
    check_val("t1_q1_lo", Q, 8'hC3);
    tick;
    check_val("t1_q_end", Q, 8'hFF);
    check_val("t1_oe_end", OE, 1'b0);
    check_val("t1_busy_end", busy, 1'b0);

    // 2: SDR word, d2 ignored
    ddr_mode = 1'b0;
    in_valid = 1'b1; in_d1 = 8'h0F; in_d2 = 8'hF0; in_last = 1'b1;
    tick;
    in_valid = 1'b0; in_last = 1'b0;
    tick;
    check_val("t2_q_hi", Q, 8'h0F);
    half_lo;
    check_val("t2_q_lo", Q, 8'h0F);
    tick;
    check_val("t2_q_end", Q, 8'hFF);
    check_val("t2_oe_end", OE, 1'b0);

    // 3: single-word bursts with in_valid held high fill the FIFO,
    //    since each burst costs two edges but a push costs one
    ddr_mode = 1'b1;
    in_last  = 1'b1;
    pushed   = 0;
    for (int e = 1; e <= 17; e++) begin
      if (pushed < 8) begin
        in_valid = 1'b1;
        in_d1    = 8'h10 + 8'(pushed);
        in_d2    = ~in_d1;
      end else begin
        in_valid = 1'b0;
      end
      rdy_before = in_ready;
      tick;
      if (in_valid && rdy_before) pushed++;
      if (e <= 9) check_val($sformatf("t3_ready_e%0d", e), in_ready, exp_rdy[e]);
      exp_q = ((e % 2 == 0) && e <= 16) ? 8'h10 + 8'((e - 2) / 2) : 8'hFF;
      check_val($sformatf("t3_q_e%0d", e), Q, exp_q);
    end
    in_valid = 1'b0; in_last = 1'b0;
    check_val("t3_busy_end", busy, 1'b0);

    // 4: underrun for three cycles, then clear
    in_valid = 1'b1; in_d1 = 8'h77; in_d2 = 8'h88; in_last = 1'b0;
    tick;
    in_valid = 1'b0;
    tick;
    check_val("t4_q_hi", Q, 8'h77);
    check_val("t4_urun0", underrun, 1'b0);
    half_lo;
    check_val("t4_q_lo", Q, 8'h88);
    tick;
    check_val("t4_ur1_q", Q, 8'hFF);
    check_val("t4_ur1_oe", OE, 1'b1);
    check_val("t4_ur1_flag", underrun, 1'b1);
    half_lo;
    check_val("t4_ur1_q_lo", Q, 8'hFF);
    tick;
    check_val("t4_ur2_q", Q, 8'hFF);
    in_valid = 1'b1; in_d1 = 8'h99; in_d2 = 8'h66; in_last = 1'b1;
    tick;
    in_valid = 1'b0; in_last = 1'b0;
    check_val("t4_ur3_q", Q, 8'hFF);
    check_val("t4_ur3_oe", OE, 1'b1);
    check_val("t4_ur3_flag", underrun, 1'b1);
    check_val("t4_ur3_cnt", underrun_cnt, c_EXP_CNT3);
    half_lo;
    check_val("t4_ur3_q_lo", Q, 8'hFF);
    clr_underrun = 1'b1;
    tick;
    clr_underrun = 1'b0;
    check_val("t4_resume_q", Q, 8'h99);
    check_val("t4_clr_flag", underrun, 1'b0);
    check_val("t4_clr_cnt", underrun_cnt, 8'd0);
    tick;
    check_val("t4_end_oe", OE, 1'b0);

    // 5: reset with three words queued
    in_last = 1'b1;
    for (int e = 0; e < 5; e++) begin
      in_valid = 1'b1;
      in_d1    = 8'hB0 + 8'(e);
      in_d2    = 8'hB0 + 8'(e);
      tick;
    end
    in_valid = 1'b0; in_last = 1'b0;
    R = 1'b1;
    tick;
    R = 1'b0;
    check_val("t5_q", Q, 8'hFF);
    check_val("t5_oe", OE, 1'b0);
    check_val("t5_busy", busy, 1'b0);
    check_val("t5_ready", in_ready, 1'b1);
    for (int e = 0; e < 6; e++) begin
      tick;
      check_val($sformatf("t5_after_q%0d", e), Q, 8'hFF);
      check_val($sformatf("t5_after_oe%0d", e), OE, 1'b0);
    end

    // 6: CE low for two edges mid-burst with in_valid high
    ddr_mode = 1'b1;
    in_valid = 1'b1; in_d1 = 8'hC1; in_d2 = 8'h1C; in_last = 1'b0;
    tick;
    in_d1 = 8'hC2; in_d2 = 8'h2C; in_last = 1'b1;
    tick;
    CE = 1'b0; in_d1 = 8'hEE; in_d2 = 8'hEE; in_last = 1'b0;
    check_val("t6_q_pre", Q, 8'hC1);
    tick;
    check_val("t6_frz1_q", Q, 8'hC1);
    check_val("t6_frz1_oe", OE, 1'b1);
    check_val("t6_frz1_busy", busy, 1'b1);
    check_val("t6_frz1_ready", in_ready, 1'b1);
    half_lo;
    check_val("t6_frz1_q_lo", Q, 8'h1C);
    tick;
    check_val("t6_frz2_q", Q, 8'hC1);
    CE = 1'b1; in_valid = 1'b0;
    tick;
    check_val("t6_res_q", Q, 8'hC2);
    half_lo;
    check_val("t6_res_q_lo", Q, 8'h2C);
    tick;
    check_val("t6_end_q", Q, 8'hFF);
    check_val("t6_end_oe", OE, 1'b0);
    tick;
    check_val("t6_nopush_q", Q, 8'hFF);
    check_val("t6_nopush_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
